// File: rtl/spi_host.sv
// spi_host -- SPI mode-0 host for a bus-bridge target.
// Frame: {rw,6'b0,addr[16]}, addr[15:8], addr[7:0], then wr_data (writes)
// or 8 read clocks after the target signals done (reads).
// Optional feature: define SPI_HOST_TIMEOUT_EN to bound the done wait by
// TIMEOUT cycles; on expiry the read phase is skipped and err_o is raised.
module spi_host #(
  parameter int unsigned DIV     = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_16_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        rw_ni,
  input  logic [16:0] addr_i,
  input  logic [7:0]  wr_data_i,
  output logic [7:0]  rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        spi_sclk_o,
  output logic        spi_cs_no,
  output logic        spi_tx_o,
  input  logic        spi_rx_i,
  input  logic        spi_done_ni
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_READ, S_GAP} state_e;

  localparam logic [8:0] HALF_END = 9'(DIV - 1);
  localparam logic [8:0] GAP_END  = 9'(2 * DIV - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;      // half-period / gap cycle counter
  logic [5:0]  bit_q, bit_d;      // completed bits in current phase
  logic [31:0] sr_q, sr_d;        // MOSI shift register, MSB is on the wire
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  sync_q;            // spi_done_ni synchronizer, [1] is safe to use
  logic        half_end;

`ifdef SPI_HOST_TIMEOUT_EN
  logic        err_q, err_d;
  logic [15:0] wcnt_q, wcnt_d;
  assign err_o = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign err_o = 1'b0;
`endif

  assign rd_data_o  = rd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign spi_sclk_o = sclk_q;
  assign spi_cs_no  = cs_q;
  // Only the write byte trails the address with real data; reads load zeros
  // there so MOSI is already 0 through WAIT and READ.
  assign spi_tx_o   = sr_q[31];

  // Next-state and datapath: SCLK toggles every DIV cycles while clocking.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SPI_HOST_TIMEOUT_EN
    err_d    = err_q;
    wcnt_d   = wcnt_q;
`endif
    half_end = (cnt_q == HALF_END);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CMD;
          rw_d    = rw_ni;
          sr_d    = {rw_ni, 6'b0, addr_i, (rw_ni ? 8'h00 : wr_data_i)};
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
`ifdef SPI_HOST_TIMEOUT_EN
          err_d   = 1'b0;
          wcnt_d  = '0;
`endif
        end
      end
      S_CMD, S_READ: begin
        cnt_d = cnt_q + 9'd1;
        if (half_end) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // rising edge: sample MISO (only meaningful while reading)
            if (state_q == S_READ) rx_d = {rx_q[6:0], spi_rx_i};
          end else begin
            // falling edge: advance MOSI
            bit_d = bit_q + 6'd1;
            sr_d  = {sr_q[30:0], 1'b0};
            if (state_q == S_CMD && bit_q == (rw_q ? 6'd23 : 6'd31)) begin
              state_d = S_WAIT;
              bit_d   = '0;
            end else if (state_q == S_READ && bit_q == 6'd7) begin
              state_d = S_GAP;
              cs_d    = 1'b1;
              rd_d    = rx_q;
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (!sync_q[1]) begin
          state_d = rw_q ? S_READ : S_GAP;
          cs_d    = ~rw_q;
        end
`ifdef SPI_HOST_TIMEOUT_EN
        else if (wcnt_q >= 16'(TIMEOUT)) begin
          state_d = S_GAP;
          cs_d    = 1'b1;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
`endif
      end
      S_GAP: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == GAP_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any frame at once.
  always_ff @(posedge clk_16_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= 2'b11;
`ifdef SPI_HOST_TIMEOUT_EN
      err_q   <= 1'b0;
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sync_q  <= {sync_q[0], spi_done_ni};
`ifdef SPI_HOST_TIMEOUT_EN
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

endmodule

// File: doc/spi_host.md
SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning SCLK half-period in clk_16_i cycles (legal 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning the maximum clk_16_i cycles spent waiting for done (legal 1..65535).
REQ-003 SHALL have port clk_16_i  input  1  16 MHz system clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request strobe, sampled only in IDLE.
REQ-006 SHALL have port rw_ni  input  1  1 = read, 0 = write.
REQ-007 SHALL have port addr_i  input  17  target bus address.
REQ-008 SHALL have port wr_data_i  input  8  write data.
REQ-009 SHALL have port rd_data_o  output  8  captured read data.
REQ-010 SHALL have port busy_o  output  1  high from accepted start until return to IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  output  1  timeout flag, valid with done_o.
REQ-013 SHALL have ports spi_sclk_o, spi_cs_no and spi_tx_o, each output 1 wide, carrying SPI clock, chip select and MOSI.
REQ-014 SHALL have ports spi_rx_i and spi_done_ni, each input 1 wide, carrying MISO and the active-low done from the PET-side SPI target.

Function
REQ-015 SHALL use SPI mode 0, MSB first: SCLK idles low, MOSI changes after falling edges, MISO is sampled on rising edges.
REQ-016 SHALL, on start_i in IDLE, latch rw_ni/addr_i/wr_data_i, assert busy_o next cycle and drive spi_cs_no low; start_i while busy SHALL be ignored.
REQ-017 SHALL send the frame: byte0 = {rw_ni, 6'b0, addr[16]}, byte1 = addr[15:8], byte2 = addr[7:0], byte3 = wr_data (writes only).
REQ-018 SHALL present the first MOSI bit at least DIV cycles before the first rising SCLK edge after CS falls.
REQ-019 SHALL use FSM states IDLE -> CMD -> WAIT -> (READ if read) -> GAP -> IDLE.
REQ-020 In CMD, SHALL shift 24 bits (read) or 32 bits (write), then enter WAIT with SCLK low and CS held low.
REQ-021 In WAIT, SHALL pass spi_done_ni through a 2-flop synchronizer and leave WAIT on the first synchronized low.
REQ-022 In READ, SHALL clock 8 bits with MOSI = 0 and shift spi_rx_i into an internal register.
REQ-023 SHALL update rd_data_o only when a read completes without error; otherwise rd_data_o SHALL hold.
REQ-024 In GAP, SHALL drive spi_cs_no high for 2*DIV cycles, then pulse done_o for 1 cycle and deassert busy_o in the same cycle.
REQ-025 SHALL generate each SCLK period as exactly 2*DIV clk_16_i cycles, with no runt pulses at frame start or end.
REQ-026 SHALL hold spi_sclk_o low whenever spi_cs_no is high.
REQ-027 SHALL accept start_i in the cycle after done_o, making back-to-back transactions legal.
REQ-028 SHALL clear err_o on every accepted start.

Reset
REQ-029 While reset_i is high, outputs SHALL be: spi_cs_no = 1, spi_sclk_o = 0, spi_tx_o = 0, busy_o = 0, done_o = 0, err_o = 0, rd_data_o = 8'h00, FSM = IDLE.
REQ-030 Reset asserted mid-transaction SHALL abort immediately with no done_o pulse; the next start after release SHALL produce a full, clean frame.

Configuration
REQ-031 With SPI_HOST_TIMEOUT_EN defined, WAIT SHALL count cycles; on exceeding TIMEOUT it SHALL skip READ, go to GAP, and assert err_o = 1 with done_o.
REQ-032 Without SPI_HOST_TIMEOUT_EN, WAIT SHALL wait indefinitely, err_o SHALL be tied 0, and TIMEOUT SHALL be unused.

Verification
REQ-033 SHALL cover: write addr 17'h08000, data 8'h41, DIV = 4 -> 32 SCLK edges on MOSI = 00 80 00 41, responder done -> done_o, err_o = 0, CS high for 8 cycles.
REQ-034 SHALL cover: read addr 17'h1E812 with responder returning 8'hA5 -> MOSI 81 E8 12 then 8 dummy bits, rd_data_o = 8'hA5 at done_o.
REQ-035 SHALL cover: SPI_HOST_TIMEOUT_EN, TIMEOUT = 100, spi_done_ni held high -> done_o after about 100 + sync + gap cycles, err_o = 1, rd_data_o unchanged, no READ clocks.
REQ-036 SHALL cover: reset_i pulsed after 10 SCLK bits of a write -> CS high and SCLK low asynchronously, no done_o; the next write frame is bit-exact.
REQ-037 SHALL cover: start_i held high continuously for two queued writes -> two frames separated by at least 2*DIV CS-high cycles, and exactly two done_o pulses.
REQ-038 SHALL cover: DIV = 2 -> SCLK period 4 cycles, the MOSI setup rule and the no-runt-pulse rule are met, and a loopback (spi_rx_i = spi_tx_o) read returns 8'h00.
